// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline writeback sources and the register-file
// write-port arbiter.
//   master : writeback side; drives stall and the request vectors, sees grants
//            and the registered register-file write signals.
//   slave  : arbiter side; the mirror image of master.
// Signals:
//   wb_stall        1     freeze the write port for this cycle
//   req_valid       N     per-requester write request
//   req_addr        N*5   requester i address in [5*i+4:5*i]
//   req_data        N*32  requester i data in [32*i+31:32*i]
//   req_grant       N     one-hot combinational grant
//   RegWrite        1     registered write enable
//   Write_register  5     registered write address
//   Write_data      32    registered write data
//   init_done       1     init sequence finished
//   contention_cnt  16    cycles with more than one valid request
interface regfile_wb_arbiter_if #(
  parameter int unsigned N = 3
);
  logic            wb_stall;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_grant;
  logic            RegWrite;
  logic [4:0]      Write_register;
  logic [31:0]     Write_data;
  logic            init_done;
  logic [15:0]     contention_cnt;

  modport master (
    output wb_stall, req_valid, req_addr, req_data,
    input  req_grant, RegWrite, Write_register, Write_data, init_done, contention_cnt
  );

  modport slave (
    input  wb_stall, req_valid, req_addr, req_data,
    output req_grant, RegWrite, Write_register, Write_data, init_done, contention_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owner of the single register-file write port. After reset it writes GP_INIT
// to r28 and SP_INIT to r29, then shares the port between N writeback
// requesters with round-robin arbitration. Grants are combinational; the
// resulting write is registered and appears one cycle later.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    regfile_wb_arbiter_if.slave (requests in, grants and write port out)
// Build option:
//   RFARB_CONTENTION_EN  when defined, contention_cnt counts RUN cycles with two
//                        or more valid requests (saturating); otherwise it is 0.
module regfile_wb_arbiter #(
  parameter int unsigned N       = 3,
  parameter logic [31:0] GP_INIT = 32'h00001800,
  parameter logic [31:0] SP_INIT = 32'h00002ffe
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StInitGp,
    StInitSp,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [4:0]      addr_arr [N];
  logic [31:0]     data_arr [N];
  logic            found;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] cand;
  logic [N-1:0]    grant;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      addr_arr[i] = bus.req_addr[5*i +: 5];
      data_arr[i] = bus.req_data[32*i +: 32];
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = PtrW'((int'(rr_ptr_q) + k) % int'(N));
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    grant      = '0;

    unique case (state_q)
      StInitGp: begin
        if (!bus.wb_stall) begin
          regwrite_d = 1'b1;
          wreg_d     = 5'd28;
          wdata_d    = GP_INIT;
          state_d    = StInitSp;
        end
      end
      StInitSp: begin
        if (!bus.wb_stall) begin
          regwrite_d = 1'b1;
          wreg_d     = 5'd29;
          wdata_d    = SP_INIT;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (!bus.wb_stall && found) begin
          grant[win] = 1'b1;
          // A write to r0 is consumed but never reaches the register file.
          regwrite_d = (addr_arr[win] != 5'd0);
          wreg_d     = addr_arr[win];
          wdata_d    = data_arr[win];
          rr_ptr_d   = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;
        end
      end
      default: begin
        state_d = StInitGp;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInitGp;
      rr_ptr_q   <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.req_grant      = grant;
  assign bus.RegWrite       = regwrite_q;
  assign bus.Write_register = wreg_q;
  assign bus.Write_data     = wdata_q;
  assign bus.init_done      = (state_q == StRun);

`ifdef RFARB_CONTENTION_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts contention even while stalled; stall only blocks the grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StRun && $countones(bus.req_valid) > 1 && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.contention_cnt = cnt_q;
`else
  assign bus.contention_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model of the spec.
module tb_regfile_wb_arbiter;
  localparam int unsigned N = 3;
  localparam logic [31:0] GP = 32'h00001800;
  localparam logic [31:0] SP = 32'h00002ffe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N(N)) bus ();

  regfile_wb_arbiter #(.N(N), .GP_INIT(GP), .SP_INIT(SP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Requester side
  logic [N-1:0] pend;
  logic [4:0]   r_addr [N];
  logic [31:0]  r_data [N];
  logic         stall;

  // Reference model: init phase 0/1 = r28/r29 pending, 2 = running
  int          m_phase;
  int          m_ptr;
  logic        m_rw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  logic [N-1:0] seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_rw    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  task automatic drive_bus();
    bus.wb_stall = stall;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_valid[i]         = pend[i];
      bus.req_addr[5*i +: 5]   = r_addr[i];
      bus.req_data[32*i +: 32] = r_data[i];
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check grant,
  // advance the model, cross the edge and retire the granted request.
  task automatic cycle(input logic rst, output logic [N-1:0] gseen);
    int g;
    logic [N-1:0] gv;
    check_eq("RegWrite", {31'd0, bus.RegWrite}, {31'd0, m_rw});
    check_eq("Write_register", {27'd0, bus.Write_register}, {27'd0, m_addr});
    check_eq("Write_data", bus.Write_data, m_data);
    check_eq("init_done", {31'd0, bus.init_done}, (m_phase == 2) ? 32'd1 : 32'd0);
    check_eq("contention_cnt", {16'd0, bus.contention_cnt}, m_cnt);
    reset = rst;
    drive_bus();
    #2;
    gseen = bus.req_grant;
    g = -1;
    if (!rst && m_phase == 2 && !stall) begin
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (m_ptr + k) % int'(N);
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    gv = '0;
    if (g >= 0) gv[g] = 1'b1;
    if (!rst) check_eq("req_grant", {29'd0, gseen}, {29'd0, gv});
    if (rst) begin
      model_reset();
    end else begin
`ifdef RFARB_CONTENTION_EN
      if (m_phase == 2 && $countones(pend) >= 2 && m_cnt < 65535) m_cnt++;
`endif
      m_rw = 1'b0;
      if (m_phase < 2) begin
        if (!stall) begin
          m_rw   = 1'b1;
          m_addr = (m_phase == 0) ? 5'd28 : 5'd29;
          m_data = (m_phase == 0) ? GP : SP;
          m_phase++;
        end
      end else if (g >= 0) begin
        m_rw   = (r_addr[g] != 5'd0);
        m_addr = r_addr[g];
        m_data = r_data[g];
        m_ptr  = (g + 1) % int'(N);
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) pend[g] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    pend[i]   = 1'b1;
    r_addr[i] = a;
    r_data[i] = d;
  endtask

  initial begin
    pend  = '0;
    stall = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    reset = 1'b1;
    drive_bus();
    @(posedge clk);
    #1;
    model_reset();
    cycle(1'b1, seen);                          // second reset cycle

    // Request waits through init, granted once running
    set_req(0, 5'd5, 32'h11110005);
    cycle(1'b0, seen);
    check_eq("init_grant_gp", {29'd0, seen}, 32'd0);
    check_eq("init_wr_gp", {27'd0, bus.Write_register}, 32'd28);
    cycle(1'b0, seen);
    check_eq("init_grant_sp", {29'd0, seen}, 32'd0);
    check_eq("init_wr_sp", bus.Write_data, SP);
    cycle(1'b0, seen);
    check_eq("first_run_grant", {29'd0, seen}, 32'd1);

    // Bring the pointer back to 0, then three-way round robin
    set_req(2, 5'd7, 32'h22220007);
    cycle(1'b0, seen);
    check_eq("wrap_grant", {29'd0, seen}, 32'd4);
    set_req(0, 5'd1, 32'hA0000001);
    set_req(1, 5'd2, 32'hA0000002);
    set_req(2, 5'd3, 32'hA0000003);
    cycle(1'b0, seen);
    check_eq("rr_grant0", {29'd0, seen}, 32'd1);
    cycle(1'b0, seen);
    check_eq("rr_grant1", {29'd0, seen}, 32'd2);
    cycle(1'b0, seen);
    check_eq("rr_grant2", {29'd0, seen}, 32'd4);

    // Write to r0 is consumed without a write
    set_req(0, 5'd0, 32'hDEADBEEF);
    cycle(1'b0, seen);
    cycle(1'b0, seen);
    check_eq("r0_no_write", {31'd0, bus.RegWrite}, 32'd0);

    // Stall blocks grant
    stall = 1'b1;
    set_req(1, 5'd9, 32'h33330009);
    cycle(1'b0, seen);
    check_eq("stall_no_grant", {29'd0, seen}, 32'd0);
    stall = 1'b0;
    cycle(1'b0, seen);
    check_eq("unstall_grant", {29'd0, seen}, 32'd2);

    // Reset in the cycle of a grant discards it and reruns init
    set_req(0, 5'd12, 32'h4444000C);
    cycle(1'b1, seen);
    check_eq("reset_rw", {31'd0, bus.RegWrite}, 32'd0);
    check_eq("reset_init_done", {31'd0, bus.init_done}, 32'd0);
    cycle(1'b0, seen);
    cycle(1'b0, seen);
    stall = 1'b1;
    set_req(1, 5'd13, 32'h4444000D);
    for (int c = 0; c < 5; c++) cycle(1'b0, seen);
`ifdef RFARB_CONTENTION_EN
    check_eq("cnt_five", {16'd0, bus.contention_cnt}, 32'd5);
`else
    check_eq("cnt_tied", {16'd0, bus.contention_cnt}, 32'd0);
`endif
    stall = 1'b0;
    cycle(1'b1, seen);
    check_eq("cnt_after_reset", {16'd0, bus.contention_cnt}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && ($urandom % 3) == 0) begin
          set_req(i, 5'($urandom), $urandom);
        end
      end
      stall = (($urandom % 5) == 0);
      cycle((($urandom % 80) == 0), seen);
    end
    stall = 1'b0;
    cycle(1'b0, seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
